// File: rtl/detect_seq_sched_if.sv
// Request/response bundle between the two bit-pattern producers, the scheduler and the result consumer.
interface detect_seq_sched_if #(
    parameter int unsigned W = 8
);
    localparam int unsigned CW = $clog2(W + 1);

    logic          REQ0_VALID;
    logic [W-1:0]  REQ0_DATA;
    logic          REQ0_READY;
    logic          REQ1_VALID;
    logic [W-1:0]  REQ1_DATA;
    logic          REQ1_READY;
    logic          RSP_VALID;
    logic          RSP_ID;
    logic [CW-1:0] RSP_COUNT;
    logic          RSP_READY;
    logic          BUSY;

    modport master (
        output REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA, RSP_READY,
        input  REQ0_READY, REQ1_READY, RSP_VALID, RSP_ID, RSP_COUNT, BUSY
    );

    modport slave (
        input  REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA, RSP_READY,
        output REQ0_READY, REQ1_READY, RSP_VALID, RSP_ID, RSP_COUNT, BUSY
    );
endinterface

// File: rtl/detect_seq_sched.sv
// Round-robin scheduler feeding two requesters' words LSB-first through an embedded
// A/B/C sequence detector; reports how many bit-steps landed in C.
module detect_seq_sched #(
    parameter int unsigned W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    detect_seq_sched_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned IW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;
    typedef enum logic [1:0] {DET_A, DET_B, DET_C} det_t;

    state_t        state, state_n;
    det_t          det, det_n;
    logic [IW-1:0] idx, idx_n;
    logic [W-1:0]  word, word_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          id, id_n;
    logic          ptr, ptr_n;
    logic          rsp_valid, rsp_valid_n;
    logic          busy, busy_n;
    logic          ready0_c, ready1_c;
    logic          gnt1_c;

    function automatic det_t det_step(input det_t s, input logic b);
        det_t r;
        case (s)
            DET_A:   r = b ? DET_B : DET_A;
            DET_B:   r = b ? DET_B : DET_C;
            DET_C:   r = b ? DET_A : DET_C;
            default: r = DET_A;
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            det       <= DET_A;
            idx       <= '0;
            word      <= '0;
            cnt       <= '0;
            id        <= 1'b0;
            ptr       <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            det       <= det_n;
            idx       <= idx_n;
            word      <= word_n;
            cnt       <= cnt_n;
            id        <= id_n;
            ptr       <= ptr_n;
            rsp_valid <= rsp_valid_n;
            busy      <= busy_n;
        end
    end

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign gnt1_c = bus.REQ1_VALID & (~bus.REQ0_VALID | ptr);

    always_comb begin
        state_n     = state;
        det_n       = det;
        idx_n       = idx;
        word_n      = word;
        cnt_n       = cnt;
        id_n        = id;
        ptr_n       = ptr;
        rsp_valid_n = rsp_valid;
        busy_n      = busy;
        ready0_c    = 1'b0;
        ready1_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (!RST && (bus.REQ0_VALID || bus.REQ1_VALID)) begin
                    ready0_c = bus.REQ0_VALID & ~gnt1_c;
                    ready1_c = gnt1_c;
                    word_n   = gnt1_c ? bus.REQ1_DATA : bus.REQ0_DATA;
                    id_n     = gnt1_c;
                    cnt_n    = '0;
                    det_n    = DET_A;
                    idx_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                det_n = det_step(det, word[idx]);
                if (det_n == DET_C) begin
                    cnt_n = cnt + CW'(1);
                end
                idx_n = idx + IW'(1);
                if (idx == IW'(W - 1)) begin
                    rsp_valid_n = 1'b1;
                    state_n     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.RSP_READY) begin
                    rsp_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    ptr_n       = ~id;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.REQ0_READY = ready0_c;
    assign bus.REQ1_READY = ready1_c;
    assign bus.RSP_VALID  = rsp_valid;
    assign bus.RSP_ID     = id;
    assign bus.RSP_COUNT  = cnt;
    assign bus.BUSY       = busy;
endmodule

// File: tb/tb_detect_seq_sched.sv
// Scoreboard bench for detect_seq_sched: accepts push model results, responses pop and compare.
module tb_detect_seq_sched;
    localparam int unsigned W = 8;

    typedef struct {
        bit          id;
        int unsigned cnt;
    } exp_t;

    logic CLK;
    logic RST;

    detect_seq_sched_if #(.W(W)) bus ();

    detect_seq_sched #(.W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned n_acc = 0;
    int unsigned n_hs = 0;
    exp_t        sb[$];
    bit          grant_log[$];
    bit          ptr_m = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    bit          spacing_on = 1'b0;
    bit          have_prev = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned ref_count(input logic [W-1:0] w);
        int unsigned s = 0;
        int unsigned n = 0;
        for (int i = 0; i < W; i++) begin
            case (s)
                0:       s = w[i] ? 1 : 0;
                1:       s = w[i] ? 1 : 2;
                default: s = w[i] ? 0 : 2;
            endcase
            if (s == 2) n++;
        end
        return n;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: predicts grants, fills the scoreboard and checks every response cycle.
    always @(negedge CLK) begin
        exp_t e;
        bit   g;
        if (RST) begin
            sb.delete();
            ptr_m      = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.REQ0_READY || bus.REQ1_READY) begin
                g = bus.REQ1_VALID && (!bus.REQ0_VALID || ptr_m);
                check("grant_id", 32'(bus.REQ1_READY), 32'(g));
                check("ready_onehot", 32'(bus.REQ0_READY && bus.REQ1_READY), 0);
                check("accept_while_busy", sb.size(), 0);
                if (spacing_on && have_prev) check("accept_spacing", cyc - acc_cyc, W + 2);
                e.id  = g;
                e.cnt = ref_count(g ? bus.REQ1_DATA : bus.REQ0_DATA);
                sb.push_back(e);
                have_prev = 1'b1;
                acc_cyc   = cyc;
                grant_log.push_back(g);
                n_acc++;
            end
            if (prev_valid && !prev_ready && !bus.RSP_VALID) check("rsp_valid_dropped", 0, 1);
            if (bus.RSP_VALID) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    if (!prev_valid) check("latency", cyc - acc_cyc, W + 1);
                    check("rsp_id", 32'(bus.RSP_ID), 32'(sb[0].id));
                    check("rsp_count", 32'(bus.RSP_COUNT), sb[0].cnt);
                    if (bus.RSP_READY) begin
                        ptr_m = !sb[0].id;
                        void'(sb.pop_front());
                        n_hs++;
                    end
                end
            end
            prev_valid = bus.RSP_VALID;
            prev_ready = bus.RSP_READY;
        end
    end

    task automatic wait_acc(input int unsigned target, input int unsigned budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            #2;
            if (n_acc >= target) done = 1'b1;
        end
        if (!done) check("accept_timeout", n_acc, target);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            #2;
            if (sb.size() == 0 && !bus.RSP_VALID) done = 1'b1;
        end
        if (!done) check("idle_timeout", sb.size(), 0);
    endtask

    task automatic send(input bit rid, input logic [W-1:0] d);
        int unsigned base = n_acc;
        @(posedge CLK);
        #1;
        if (rid) begin
            bus.REQ1_VALID = 1'b1;
            bus.REQ1_DATA  = d;
        end else begin
            bus.REQ0_VALID = 1'b1;
            bus.REQ0_DATA  = d;
        end
        wait_acc(base + 1, 40);
        @(posedge CLK);
        #1;
        if (rid) bus.REQ1_VALID = 1'b0;
        else     bus.REQ0_VALID = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int unsigned base;
        int unsigned hs_before;
        bit          exp_order[4];
        bit          seen;

        RST            = 1'b1;
        bus.REQ0_VALID = 1'b1;
        bus.REQ0_DATA  = 8'h02;
        bus.REQ1_VALID = 1'b0;
        bus.REQ1_DATA  = '0;
        bus.RSP_READY  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rsp_valid", 32'(bus.RSP_VALID), 0);
        check("rst_rsp_id", 32'(bus.RSP_ID), 0);
        check("rst_rsp_count", 32'(bus.RSP_COUNT), 0);
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_ready0", 32'(bus.REQ0_READY), 0);
        bus.REQ0_VALID = 1'b0;
        RST            = 1'b0;

        // Single words from each requester
        send(1'b0, 8'h02);
        #1;
        check("busy_in_shift", 32'(bus.BUSY), 1);
        wait_idle();
        check("busy_after_rsp", 32'(bus.BUSY), 0);
        send(1'b1, 8'h55); wait_idle();
        send(1'b1, 8'hFF); wait_idle();
        send(1'b1, 8'h00); wait_idle();

        // Both requesters continuously valid: alternating grants at W+2 spacing
        do_reset();
        grant_log.delete();
        have_prev  = 1'b0;
        spacing_on = 1'b1;
        base       = n_acc;
        bus.REQ0_DATA  = 8'h02;
        bus.REQ1_DATA  = 8'h55;
        bus.REQ0_VALID = 1'b1;
        bus.REQ1_VALID = 1'b1;
        wait_acc(base + 4, 100);
        @(posedge CLK);
        #1;
        bus.REQ0_VALID = 1'b0;
        bus.REQ1_VALID = 1'b0;
        spacing_on     = 1'b0;
        wait_idle();
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("grant_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end

        // Consumer stall: result held, other requester must wait
        bus.RSP_READY = 1'b0;
        send(1'b0, 8'h55);
        bus.REQ1_DATA  = 8'hFF;
        bus.REQ1_VALID = 1'b1;
        base = n_acc;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            #2;
            if (bus.RSP_VALID) seen = 1'b1;
        end
        check("stall_rsp_seen", 32'(seen), 1);
        repeat (5) @(negedge CLK);
        #2;
        check("stall_no_accept", n_acc, base);
        hs_before = n_hs;
        @(posedge CLK);
        #1;
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        #2;
        check("hs_on_first_ready", n_hs, hs_before + 1);
        wait_acc(base + 1, 10);
        @(posedge CLK);
        #1;
        bus.REQ1_VALID = 1'b0;
        wait_idle();

        // Data changed after accept must not affect the result
        send(1'b0, 8'h02);
        bus.REQ0_DATA = 8'hFF;
        wait_idle();

        // Reset at shift index 3 aborts the job
        base = n_acc;
        @(posedge CLK);
        #1;
        bus.REQ1_VALID = 1'b1;
        bus.REQ1_DATA  = 8'h02;
        wait_acc(base + 1, 20);
        @(posedge CLK);
        #1;
        bus.REQ1_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_rsp_valid", 32'(bus.RSP_VALID), 0);
        check("abort_rsp_id", 32'(bus.RSP_ID), 0);
        check("abort_rsp_count", 32'(bus.RSP_COUNT), 0);
        check("abort_busy", 32'(bus.BUSY), 0);
        hs_before = n_hs;
        repeat (15) @(negedge CLK);
        #2;
        check("abort_no_rsp", n_hs, hs_before);
        send(1'b0, 8'h55);
        wait_idle();

        // A few random words on alternating requesters
        for (int i = 0; i < 6; i++) begin
            send(1'(i % 2), W'($urandom));
            wait_idle();
        end

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
